// File: rtl/dec_converter_arbiter_if.sv
// Request, source and converter-side signals of the shared decode-path width converter arbiter.
// The master modport is the arbiter's view; slave is the view of the channels and converter around it.
interface dec_converter_arbiter_if #(
    parameter int NumChannels    = 4,
    parameter int InputDataWidth = 32,
    parameter int LengthWidth    = 16
);
    logic [NumChannels-1:0]                iReq;
    logic [NumChannels*LengthWidth-1:0]    iLength;
    logic [NumChannels-1:0]                iSrcDataValid;
    logic [NumChannels*InputDataWidth-1:0] iSrcData;
    logic [NumChannels-1:0]                oSrcReady;
    logic [NumChannels-1:0]                oGrant;
    logic [NumChannels-1:0]                oDone;
    logic                                  oBusy;
    logic                                  oConvSrcValid;
    logic [InputDataWidth-1:0]             oConvSrcData;
    logic                                  iConvReady;
    logic                                  iConvDataValid;

    modport master (
        input  iReq, iLength, iSrcDataValid, iSrcData, iConvReady, iConvDataValid,
        output oSrcReady, oGrant, oDone, oBusy, oConvSrcValid, oConvSrcData
    );

    modport slave (
        output iReq, iLength, iSrcDataValid, iSrcData, iConvReady, iConvDataValid,
        input  oSrcReady, oGrant, oDone, oBusy, oConvSrcValid, oConvSrcData
    );
endinterface

// File: rtl/dec_converter_arbiter.sv
// Round-robin arbiter that lends the shared 32-to-16 converter to one channel per burst,
// muxes that channel's words in, and holds the grant until the converter has drained.
module dec_converter_arbiter #(
    parameter int NumChannels    = 4,
    parameter int InputDataWidth = 32,
    parameter int LengthWidth    = 16
) (
    input  logic                     iClock,
    input  logic                     iReset,
    dec_converter_arbiter_if.master  bus
);
    localparam int IdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StTransfer = 2'd1;
    localparam logic [1:0] StDrain    = 2'd2;
    localparam logic [1:0] StDone     = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IdxWidth-1:0]    grantIdx_q, grantIdx_d;
    logic [IdxWidth-1:0]    pointer_q, pointer_d;
    logic [NumChannels-1:0] grant_q, grant_d;
    logic [LengthWidth-1:0] length_q, length_d;
    logic [LengthWidth-1:0] count_q, count_d;

    logic                   anyReq;
    logic [IdxWidth-1:0]    winIdx;
    logic [LengthWidth-1:0] winLength;
    logic [LengthWidth-1:0] countInc;
    logic                   inTransfer;
    logic                   srcValidG;
    logic                   accept;
    logic [NumChannels-1:0] srcReady;
    int                     cand;

    // Scan from the largest offset down so the nearest requester after the pointer wins.
    always_comb begin
        anyReq = |bus.iReq;
        winIdx = pointer_q;
        cand   = 0;
        for (int off = NumChannels; off >= 1; off--) begin
            cand = (int'(pointer_q) + off) % NumChannels;
            if (bus.iReq[IdxWidth'(cand)]) begin
                winIdx = IdxWidth'(cand);
            end
        end
        winLength = bus.iLength[int'(winIdx)*LengthWidth +: LengthWidth];
    end

    assign inTransfer = (state_q == StTransfer);
    assign srcValidG  = bus.iSrcDataValid[grantIdx_q];
    assign accept     = bus.oConvSrcValid & bus.iConvReady;
    assign countInc   = count_q + LengthWidth'(1);

    always_comb begin
        srcReady = '0;
        if (inTransfer && bus.iConvReady && srcValidG) begin
            srcReady[grantIdx_q] = 1'b1;
        end
    end

    assign bus.oSrcReady     = srcReady;
    assign bus.oConvSrcValid = inTransfer & srcValidG;
    assign bus.oConvSrcData  = inTransfer ?
                               bus.iSrcData[int'(grantIdx_q)*InputDataWidth +: InputDataWidth] : '0;
    assign bus.oGrant        = grant_q;
    assign bus.oDone         = (state_q == StDone) ? grant_q : '0;
    assign bus.oBusy         = (state_q != StIdle);

    // A zero-length grant passes through Drain so it spans two cycles and the converter is confirmed idle.
    always_comb begin
        state_d    = state_q;
        grantIdx_d = grantIdx_q;
        pointer_d  = pointer_q;
        grant_d    = grant_q;
        length_d   = length_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                if (anyReq) begin
                    grantIdx_d = winIdx;
                    length_d   = winLength;
                    count_d    = '0;
                    grant_d    = NumChannels'(1) << winIdx;
                    state_d    = (winLength == '0) ? StDrain : StTransfer;
                end
            end
            StTransfer: begin
                if (accept) begin
                    count_d = countInc;
                    if (countInc == length_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!bus.iConvDataValid) begin
                    state_d = StDone;
                end
            end
            default: begin
                grant_d   = '0;
                pointer_d = grantIdx_q;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= StIdle;
            grantIdx_q <= '0;
            pointer_q  <= IdxWidth'(NumChannels - 1);
            grant_q    <= '0;
            length_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            grantIdx_q <= grantIdx_d;
            pointer_q  <= pointer_d;
            grant_q    <= grant_d;
            length_q   <= length_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_dec_converter_arbiter.sv
// Directed bench for dec_converter_arbiter with a behavioural 32-to-16 converter and per-channel word sources.
module tb_dec_converter_arbiter;
    logic iClock;
    logic iReset;
    logic dstReady;
    int   total;
    int   bad;

    dec_converter_arbiter_if #(.NumChannels(4), .InputDataWidth(32), .LengthWidth(16)) bus ();

    dec_converter_arbiter #(.NumChannels(4), .InputDataWidth(32), .LengthWidth(16)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Behavioural converter: takes a word only when empty, then emits the high and low halves.
    logic [1:0]  cvCnt;
    logic [31:0] cvReg;
    logic [15:0] convOut;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            cvCnt <= 2'd0;
            cvReg <= '0;
        end else if (cvCnt == 2'd0) begin
            if (bus.oConvSrcValid) begin
                cvReg <= bus.oConvSrcData;
                cvCnt <= 2'd2;
            end
        end else if (dstReady) begin
            cvCnt <= cvCnt - 2'd1;
        end
    end

    assign bus.iConvReady     = (cvCnt == 2'd0);
    assign bus.iConvDataValid = (cvCnt != 2'd0);
    assign convOut            = (cvCnt == 2'd2) ? cvReg[31:16] : cvReg[15:0];

    logic [31:0]  wordTable [16];
    logic [1:0]   srcIdx [4];
    logic [127:0] srcDataBus;

    always_comb begin
        srcDataBus = '0;
        for (int c = 0; c < 4; c++) begin
            srcDataBus[c*32 +: 32] = wordTable[c*4 + int'(srcIdx[c])];
        end
    end
    assign bus.iSrcData = srcDataBus;

    // Monitors for accepted words, done pulses and converter output; all cleared by reset.
    int          srcReadyCnt [4];
    int          doneCnt [4];
    int          doneAll [4];
    logic        convValidSeen;
    logic [15:0] outQ [$];

    always @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            for (int c = 0; c < 4; c++) begin
                srcIdx[c]      <= 2'd0;
                srcReadyCnt[c] <= 0;
                doneCnt[c]     <= 0;
            end
            convValidSeen <= 1'b0;
            outQ.delete();
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (bus.oSrcReady[c]) begin
                    srcIdx[c]      <= srcIdx[c] + 2'd1;
                    srcReadyCnt[c] <= srcReadyCnt[c] + 1;
                end
                if (bus.oDone[c]) doneCnt[c] <= doneCnt[c] + 1;
            end
            if (bus.oConvSrcValid) convValidSeen <= 1'b1;
            if (bus.iConvDataValid && dstReady) outQ.push_back(convOut);
        end
    end

    initial for (int c = 0; c < 4; c++) doneAll[c] = 0;
    always @(posedge iClock) begin
        for (int c = 0; c < 4; c++) begin
            if (!iReset && bus.oDone[c]) doneAll[c] <= doneAll[c] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] valid,
                                 input logic [63:0] lengths, input logic dst);
        bus.iReq          = req;
        bus.iSrcDataValid = valid;
        bus.iLength       = lengths;
        dstReady          = dst;
    endtask

    task automatic resetDut();
        iReset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 64'd0, 1'b1);
        repeat (2) @(posedge iClock);
        #2;
        iReset = 1'b0;
    endtask

    task automatic waitDone(input int ch, input int budget);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            step();
            if (bus.oDone[ch]) found = 1'b1;
        end
        checkOutput($sformatf("done_seen_ch%0d", ch), found, 1'b1);
    endtask

    logic [3:0] expGrant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] grantSeq [5];
    int         grantCyc [5];
    int         doneCyc [5];
    int         nG;
    int         nD;
    logic [3:0] prevG;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) wordTable[i] = 32'h0F0F_0000 + i;
        wordTable[0] = 32'hA1B2C3D4;
        wordTable[1] = 32'h11223344;
        wordTable[2] = 32'h55667788;
        wordTable[4] = 32'hDEADBEEF;
        wordTable[5] = 32'h0BADF00D;

        // Reset state
        resetDut();
        checkOutput("rst_grant", bus.oGrant, 4'b0000);
        checkOutput("rst_misc", {bus.oBusy, bus.oDone, bus.oSrcReady, bus.oConvSrcValid}, 10'd0);
        checkOutput("rst_data", bus.oConvSrcData, 32'd0);

        // Single burst on ch0, length 3
        step();
        applyStimulus(4'b0001, 4'b0001, 64'd3, 1'b1);
        step();
        checkOutput("burst_grant", bus.oGrant, 4'b0001);
        checkOutput("burst_busy", bus.oBusy, 1'b1);
        bus.iReq = 4'b0000;
        waitDone(0, 40);
        checkOutput("burst_conv_idle_at_done", bus.iConvDataValid, 1'b0);
        checkOutput("burst_accepts", srcReadyCnt[0], 3);
        checkOutput("burst_out_count", outQ.size(), 6);
        checkOutput("burst_w0", outQ[0], 16'hA1B2);
        checkOutput("burst_w1", outQ[1], 16'hC3D4);
        checkOutput("burst_w2", outQ[2], 16'h1122);
        checkOutput("burst_w3", outQ[3], 16'h3344);
        checkOutput("burst_w4", outQ[4], 16'h5566);
        checkOutput("burst_w5", outQ[5], 16'h7788);
        step();
        checkOutput("burst_after_done", {bus.oDone, bus.oGrant, bus.oBusy}, 9'd0);
        checkOutput("burst_done_count", doneCnt[0], 1);

        // Round-robin with all channels requesting length 1
        resetDut();
        step();
        applyStimulus(4'b1111, 4'b1111, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b1);
        nG = 0;
        nD = 0;
        prevG = 4'b0000;
        for (int cyc = 0; cyc < 200 && nG < 5; cyc++) begin
            step();
            if (bus.oGrant != 4'b0000 && prevG == 4'b0000) begin
                grantSeq[nG] = bus.oGrant;
                grantCyc[nG] = cyc;
                nG++;
            end
            if (bus.oDone != 4'b0000 && nD < 5) begin
                doneCyc[nD] = cyc;
                nD++;
            end
            prevG = bus.oGrant;
        end
        bus.iReq = 4'b0000;
        checkOutput("rr_grant_count", nG, 5);
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("rr_grant%0d", n), grantSeq[n], expGrant[n]);
        end
        for (int n = 1; n < 5; n++) begin
            checkOutput($sformatf("rr_gap%0d", n), grantCyc[n] - doneCyc[n-1], 2);
        end
        waitDone(0, 50);

        // Zero-length request on ch2
        resetDut();
        step();
        applyStimulus(4'b0100, 4'b0100, {16'd0, 16'd0, 16'd0, 16'd0}, 1'b1);
        step();
        checkOutput("zero_grant_c1", bus.oGrant, 4'b0100);
        checkOutput("zero_done_c1", bus.oDone, 4'b0000);
        checkOutput("zero_cvalid_c1", bus.oConvSrcValid, 1'b0);
        bus.iReq = 4'b0000;
        step();
        checkOutput("zero_grant_c2", bus.oGrant, 4'b0100);
        checkOutput("zero_done_c2", bus.oDone, 4'b0100);
        step();
        checkOutput("zero_after", {bus.oGrant, bus.oDone}, 8'd0);
        checkOutput("zero_no_conv", convValidSeen, 1'b0);

        // Source toggling and destination stall on ch1, length 2
        resetDut();
        step();
        applyStimulus(4'b0010, 4'b0010, {16'd0, 16'd0, 16'd2, 16'd0}, 1'b1);
        step();
        bus.iReq = 4'b0000;
        for (int n = 0; n < 40 && srcReadyCnt[1] < 2; n++) begin
            bus.iSrcDataValid[1] = ~bus.iSrcDataValid[1];
            step();
        end
        checkOutput("stall_accepts", srcReadyCnt[1], 2);
        dstReady = 1'b0;
        bus.iSrcDataValid = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            step();
            checkOutput($sformatf("stall_drain%0d", n),
                        {bus.oBusy, bus.oGrant, bus.oDone, bus.oConvSrcValid}, {1'b1, 4'b0010, 4'b0000, 1'b0});
        end
        dstReady = 1'b1;
        waitDone(1, 20);
        checkOutput("stall_out_count", outQ.size(), 4);
        checkOutput("stall_w0", outQ[0], 16'hDEAD);
        checkOutput("stall_w1", outQ[1], 16'hBEEF);
        checkOutput("stall_w2", outQ[2], 16'h0BAD);
        checkOutput("stall_w3", outQ[3], 16'hF00D);

        // Asynchronous reset during a ch3 burst
        resetDut();
        step();
        applyStimulus(4'b1000, 4'b1000, {16'd4, 16'd0, 16'd0, 16'd0}, 1'b1);
        step();
        checkOutput("rmid_grant", bus.oGrant, 4'b1000);
        step();
        #3;
        iReset = 1'b1;
        #1;
        checkOutput("rmid_grant_clr", bus.oGrant, 4'b0000);
        checkOutput("rmid_misc_clr", {bus.oBusy, bus.oDone, bus.oSrcReady, bus.oConvSrcValid}, 10'd0);
        checkOutput("rmid_data_clr", bus.oConvSrcData, 32'd0);
        applyStimulus(4'b1001, 4'b1001, {16'd1, 16'd0, 16'd0, 16'd1}, 1'b1);
        @(posedge iClock);
        #2;
        iReset = 1'b0;
        step();
        checkOutput("rmid_ch0_wins", bus.oGrant, 4'b0001);
        bus.iReq = 4'b0000;
        waitDone(0, 50);
        checkOutput("rmid_ch3_no_done", doneAll[3], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
